// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic computing (DSC) decoder.
// Contents:
//   SNG_WIDTH_DEF / NUM_INPUTS_DEF : default operand width and operand count
//   frame_log2_f / acc_w_f         : derived frame length exponent and count width
//   state_t                        : 2-bit decoder state encoding
package dsc_pkg;

    localparam int SNG_WIDTH_DEF  = 8;
    localparam int NUM_INPUTS_DEF = 4;

    // A deterministic frame visits every combination of all operand SNG
    // states, so its length is 2^(operands * bits-per-operand).
    function automatic int frame_log2_f(input int sng_width, input int num_inputs);
        return sng_width * num_inputs;
    endfunction

    // One extra bit so an all-ones frame (count = 2^FRAME_LOG2) is representable.
    function automatic int acc_w_f(input int sng_width, input int num_inputs);
        return sng_width * num_inputs + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dsc_frame_ctr.sv
// Bit-position counter for one stochastic frame.
// Ports:
//   clk   : clock
//   rst   : synchronous active-low reset
//   clr   : synchronous clear (takes priority over en)
//   en    : advance the position by one
//   count : current bit position within the frame
//   last  : count is at the final position of the frame (all ones)
module dsc_frame_ctr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    assign last  = &r_count;

endmodule

// File: rtl/dsc_s2b_dec.sv
// Framed stochastic-to-binary decoder. Counts ones over one deterministic
// frame of 2^FRAME_LOG2 qualified bits and presents the count through a
// valid/ready result port.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start             : one-cycle request to begin a frame (IDLE, or HOLD with handshake)
//   sn_in, sn_valid   : stochastic bit and its qualifier
//   z                 : exact ones count of the last completed frame (ACC_W bits)
//   z_norm            : top SNG_WIDTH bits of the count, saturated on a full frame
//   out_valid/out_ready : result handshake
//   busy              : high while accumulating
//   ov                : one-cycle pulse when a frame completes
module dsc_s2b_dec
    import dsc_pkg::*;
#(
    parameter  int SNG_WIDTH  = SNG_WIDTH_DEF,
    parameter  int NUM_INPUTS = NUM_INPUTS_DEF,
    localparam int FRAME_LOG2 = frame_log2_f(SNG_WIDTH, NUM_INPUTS),
    localparam int ACC_W      = acc_w_f(SNG_WIDTH, NUM_INPUTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sn_in,
    input  logic                 sn_valid,
    output logic [ACC_W-1:0]     z,
    output logic [SNG_WIDTH-1:0] z_norm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 ov
);

    state_t                 r_state;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_z;
    logic [SNG_WIDTH-1:0]   r_z_norm;
    logic                   r_out_valid;
    logic                   r_busy;
    logic                   r_ov;

    logic [FRAME_LOG2-1:0]  w_cnt;
    logic                   w_last;
    logic                   w_ctr_clr;
    logic                   w_ctr_en;
    logic [ACC_W-1:0]       w_sum;
    logic [SNG_WIDTH-1:0]   w_sum_norm;
    logic                   w_unused_cnt;

    // The counter is cleared whenever a new frame is accepted: from IDLE, or
    // from HOLD when the result handshake and a new start coincide.
    assign w_ctr_clr = start && ((r_state == IDLE) ||
                                 ((r_state == HOLD) && out_ready));
    assign w_ctr_en  = (r_state == ACCUM) && sn_valid;

    dsc_frame_ctr #(
        .WIDTH (FRAME_LOG2)
    ) u_frame_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_ctr_clr),
        .en    (w_ctr_en),
        .count (w_cnt),
        .last  (w_last)
    );

    // Bit position is only observed for debug; control uses the last flag.
    assign w_unused_cnt = ^w_cnt;

    // Count including the bit being sampled this cycle; the MSB is only set
    // for an all-ones frame, where the normalized value saturates.
    assign w_sum      = r_acc + ACC_W'(sn_in);
    assign w_sum_norm = w_sum[ACC_W-1] ? '1 : w_sum[FRAME_LOG2-1 -: SNG_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_z         <= '0;
            r_z_norm    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sn_valid) begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_z         <= w_sum;
                            r_z_norm    <= w_sum_norm;
                            r_out_valid <= 1'b1;
                            r_ov        <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ACCUM;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign z         = r_z;
    assign z_norm    = r_z_norm;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign ov        = r_ov;

endmodule
